// File: rtl/hilo_scheduler.sv
// ---------------------------------------------------------------------------
// hilo_scheduler
//
// Owns the HI/LO write ports of the register file. It accepts multiply,
// divide and move-to-HI/LO requests from EX and computes the result over
// several cycles. The pipeline is stalled while an op is in flight. Each
// accepted op ends in exactly one write-back cycle, during which the
// matching HI/LO strobes are raised.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      exception flush; aborts an in-flight MUL/DIV/FIX
//   req_valid  request present this cycle
//   req_op     0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6/7 never accepted)
//   req_a      rs: dividend / multiplicand / MTHI-MTLO data
//   req_b      rt: divisor / multiplier
//   req_ready  high only when idle and not in reset
//   stall      high whenever an op is in flight
//   hi_we      HI write strobe
//   hi_data    HI write data (holds last value between writes)
//   lo_we      LO write strobe
//   lo_data    LO write data (holds last value between writes)
//   div_zero   one-cycle pulse in write-back of a divide by zero
// ---------------------------------------------------------------------------
module hilo_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic        stall,
    output logic        hi_we,
    output logic [31:0] hi_data,
    output logic        lo_we,
    output logic [31:0] lo_data,
    output logic        div_zero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [4:0] LAST_STEP = 5'd31;

    // Absolute value used to feed the unsigned divider. 0x80000000 maps to
    // 0x80000000, which read as unsigned is exactly 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] v,
                                              input logic        is_signed);
        if (is_signed && v[31]) begin
            return -v;
        end
        return v;
    endfunction

    // Restores the sign of a divider result; truncation to 32 bits is
    // implicit, so 2^31 negated wraps to 0x80000000.
    function automatic logic [31:0] apply_sign(input logic [31:0] v,
                                               input logic        neg);
        return neg ? -v : v;
    endfunction

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;         // current arithmetic op is signed
    logic [31:0] opa_q, opa_d;         // latched multiplicand
    logic [31:0] opb_q, opb_d;         // latched multiplier
    logic [32:0] dvs_q, dvs_d;         // divisor magnitude
    logic [31:0] rem_q, rem_d;         // partial remainder
    logic [31:0] quo_q, quo_d;         // dividend shifting out / quotient shifting in
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        wr_hi_q, wr_hi_d;
    logic        wr_lo_q, wr_lo_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // -----------------------------------------------------------------------
    // Request acceptance
    // -----------------------------------------------------------------------
    logic req_legal;
    logic accept;

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign req_legal = (req_op <= OP_MTLO);
    assign accept    = req_valid && req_ready && !flush && req_legal;

    // -----------------------------------------------------------------------
    // Multiplier: both operands extended to full width so a single signed
    // multiply serves MULT (sign-extended) and MULTU (zero-extended).
    // -----------------------------------------------------------------------
    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic signed [63:0] product;

    always_comb begin
        mul_a   = {{32{sgn_q & opa_q[31]}}, opa_q};
        mul_b   = {{32{sgn_q & opb_q[31]}}, opb_q};
        product = mul_a * mul_b;
    end

    // -----------------------------------------------------------------------
    // One restoring divide step. The remainder is always below the divisor
    // magnitude (< 2^32), so after the shift it needs at most 33 bits.
    // -----------------------------------------------------------------------
    logic [32:0] div_shift;
    logic        div_fits;
    logic [31:0] rem_step;
    logic [31:0] quo_step;

    always_comb begin
        div_shift = {rem_q, quo_q[31]};
        div_fits  = (div_shift >= dvs_q);
        rem_step  = div_fits ? 32'(div_shift - dvs_q) : div_shift[31:0];
        quo_step  = {quo_q[30:0], div_fits};
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        wr_hi_d   = wr_hi_q;
        wr_lo_d   = wr_lo_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // DIV/MULT have op[0]=0 and are the signed variants.
                    sgn_d   = ~req_op[0];
                    opa_d   = req_a;
                    opb_d   = req_b;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    wr_hi_d = 1'b1;
                    wr_lo_d = 1'b1;
                    case (req_op)
                        OP_MTHI: begin
                            hi_d    = req_a;
                            wr_lo_d = 1'b0;
                            state_d = S_WB;
                        end
                        OP_MTLO: begin
                            lo_d    = req_a;
                            wr_hi_d = 1'b0;
                            state_d = S_WB;
                        end
                        OP_MULT, OP_MULTU: begin
                            state_d = S_MUL;
                        end
                        default: begin
                            if (req_b == '0) begin
                                // Divide by zero short-circuits to write-back
                                // with a fixed result.
                                hi_d    = req_a;
                                lo_d    = '1;
                                dz_d    = 1'b1;
                                state_d = S_WB;
                            end else begin
                                quo_d     = magnitude(req_a, ~req_op[0]);
                                rem_d     = '0;
                                dvs_d     = {1'b0, magnitude(req_b, ~req_op[0])};
                                neg_quo_d = ~req_op[0] & (req_a[31] ^ req_b[31]);
                                neg_rem_d = ~req_op[0] & req_a[31];
                                state_d   = S_DIV;
                            end
                        end
                    endcase
                end
            end

            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    state_d = S_WB;
                end
            end

            S_DIV: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    if (cnt_q == LAST_STEP) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end

            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = apply_sign(rem_q, neg_rem_q);
                    lo_d    = apply_sign(quo_q, neg_quo_q);
                    state_d = S_WB;
                end
            end

            // The op is committed once in write-back, so flush is ignored.
            S_WB: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            wr_hi_q   <= 1'b0;
            wr_lo_q   <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            wr_hi_q   <= wr_hi_d;
            wr_lo_q   <= wr_lo_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from state or taken straight from registers
    // -----------------------------------------------------------------------
    assign stall    = (state_q != S_IDLE);
    assign hi_we    = (state_q == S_WB) && wr_hi_q;
    assign lo_we    = (state_q == S_WB) && wr_lo_q;
    assign div_zero = (state_q == S_WB) && dz_q;
    assign hi_data  = hi_q;
    assign lo_data  = lo_q;

endmodule

// File: tb/tb_hilo_scheduler.sv
module tb_hilo_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        req_ready;
    logic        stall;
    logic        hi_we;
    logic [31:0] hi_data;
    logic        lo_we;
    logic [31:0] lo_data;
    logic        div_zero;

    hilo_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .stall     (stall),
        .hi_we     (hi_we),
        .hi_data   (hi_data),
        .lo_we     (lo_we),
        .lo_data   (lo_data),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          hwe;
        bit          lwe;
        bit          dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          prev_busy = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference model: the architectural result of one op, the cycle in which
    // its write strobe must be seen, and how many cycles the unit stays busy.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int acc, output int busy);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] pu;
        e = '{default: 0};
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            3'd4: begin e.hwe = 1; e.hi = a; busy = 1; end
            3'd5: begin e.lwe = 1; e.lo = a; busy = 1; end
            3'd0: begin
                p = sa * sbv;
                e.hwe = 1; e.lwe = 1; e.hi = p[63:32]; e.lo = p[31:0]; busy = 2;
            end
            3'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                e.hwe = 1; e.lwe = 1; e.hi = pu[63:32]; e.lo = pu[31:0]; busy = 2;
            end
            default: begin
                e.hwe = 1; e.lwe = 1;
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1; busy = 1;
                end else if (op == 3'd2) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    e.hi = r[31:0]; e.lo = q[31:0]; busy = 34;
                end else begin
                    e.hi = a % b; e.lo = a / b; busy = 34;
                end
            end
        endcase
        e.cyc = acc + busy - 1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Presents a request and holds it until the DUT is ready; returns the
    // number of cycles spent waiting.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int waited);
        exp_t e;
        int   busy;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < 60) begin
            check("stall_while_busy", 64'(stall), 64'(1));
            tick();
            waited++;
        end
        if (req_ready !== 1'b1) begin
            check("ready_timeout", 64'(req_ready), 64'(1));
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        e = model(op, a, b, cyc, busy);
        prev_busy = busy;
        if (push) begin
            exp_q.push_back(e);
            if (e.hwe) last_hi = e.hi;
            if (e.lwe) last_lo = e.lo;
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_wait);
        int w;
        issue(op, a, b, 1'b1, w);
        check("issue_wait", 64'(w), 64'(exp_wait));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares every write strobe against the scoreboard.
    exp_t mon_e;
    always @(negedge clk) begin
        if (hi_we === 1'b1 || lo_we === 1'b1 || div_zero === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'({hi_we, lo_we, div_zero}), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("hi_we", 64'(hi_we), 64'(mon_e.hwe));
                check("lo_we", 64'(lo_we), 64'(mon_e.lwe));
                check("div_zero", 64'(div_zero), 64'(mon_e.dz));
                if (mon_e.hwe) check("hi_data", 64'(hi_data), 64'(mon_e.hi));
                if (mon_e.lwe) check("lo_data", 64'(lo_data), 64'(mon_e.lo));
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            mon_e = exp_q.pop_front();
            check("missed_write", 64'(cyc), 64'(mon_e.cyc));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          gap;
        int          ew;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_we", 64'({hi_we, lo_we, div_zero}), 64'(0));
        check("rst_hi_data", 64'(hi_data), 64'(0));
        check("rst_lo_data", 64'(lo_data), 64'(0));
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(req_ready), 64'(1));

        // Directed sequence, each request issued right after the previous accept
        run(3'd4, 32'h1234_5678, 32'd0, 0);
        run(3'd5, 32'h9ABC_DEF0, 32'd0, 1);
        run(3'd0, 32'hFFFF_FFFE, 32'd3, 1);
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run(3'd2, 32'd5, 32'd0, 2);
        run(3'd3, 32'd100, 32'd7, 1);
        run(3'd2, 32'hFFFF_FFF9, 32'd2, 34);
        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        run(3'd0, 32'd7, 32'hFFFF_FFF7, 34);
        repeat (4) tick();

        // Flush mid-divide at count 10
        issue(3'd3, 32'd1000, 32'd7, 1'b0, w);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_div_ready", 64'(req_ready), 64'(1));
        check("flush_div_stall", 64'(stall), 64'(0));
        check("flush_div_hold_hi", 64'(hi_data), 64'(last_hi));
        check("flush_div_hold_lo", 64'(lo_data), 64'(last_lo));

        // Reset mid-divide at count 10
        issue(3'd3, 32'd1000, 32'd7, 1'b0, w);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("rst_div_ready", 64'(req_ready), 64'(0));
        check("rst_div_stall", 64'(stall), 64'(0));
        check("rst_div_we", 64'({hi_we, lo_we, div_zero}), 64'(0));
        check("rst_div_hi", 64'(hi_data), 64'(0));
        check("rst_div_lo", 64'(lo_data), 64'(0));
        rst = 1'b0;
        last_hi = 32'd0;
        last_lo = 32'd0;
        tick();
        check("rst_div_ready_after", 64'(req_ready), 64'(1));

        // Flush during write-back must not cancel the write
        issue(3'd0, 32'd6, 32'd7, 1'b1, w);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_wb_stall", 64'(stall), 64'(0));

        // Flush in idle blocks accept
        flush = 1'b1;
        req_valid = 1'b1;
        req_op = 3'd4;
        req_a = 32'hDEAD_BEEF;
        repeat (3) begin
            tick();
            check("flush_idle_stall", 64'(stall), 64'(0));
        end
        req_valid = 1'b0;
        flush = 1'b0;

        // Illegal ops never accepted
        for (int k = 6; k < 8; k++) begin
            req_valid = 1'b1;
            req_op = 3'(k);
            req_a = 32'h5555_AAAA;
            repeat (3) begin
                tick();
                check("illegal_stall", 64'(stall), 64'(0));
            end
            req_valid = 1'b0;
        end

        // Randomized traffic with random idle gaps
        prev_busy = 0;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 5));
            a   = pick();
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            gap = int'($urandom_range(0, 2));
            ew  = (prev_busy > gap) ? prev_busy - gap : 0;
            repeat (gap) tick();
            issue(op, a, b, 1'b1, w);
            check("rand_wait", 64'(w), 64'(ew));
        end

        // Drain
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick();
        repeat (2) tick();
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_scheduler.md
# hilo_scheduler

Multi-cycle controller that owns the HI/LO write ports of the register file. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the EX stage and computes products and quotients/remainders, with a 32-iteration restoring divider for division. It drives one HI/LO write burst per operation and stalls the pipeline while an operation is in flight, so no stage reads or writes HI/LO during that time.

## Interface
- No parameters; all widths are fixed (32-bit operands, 64-bit HI:LO).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous and active-high.
- flush  in  1  exception flush; aborts an in-flight arithmetic op.
- req_valid  in  1  request present this cycle.
- req_op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are ignored (no accept).
- req_a  in  32  rs value: dividend, multiplicand, or MTHI/MTLO data.
- req_b  in  32  rt value: divisor or multiplier.
- req_ready  out  1  high only in IDLE with rst=0.
- stall  out  1  high whenever state≠IDLE.
- hi_we  out  1  HI write strobe to the register file.
- hi_data  out  32  HI write data.
- lo_we  out  1  LO write strobe.
- lo_data  out  32  LO write data.
- div_zero  out  1  one-cycle pulse in WB of a divide whose divisor is 0.

## Operation
- States: IDLE, MUL, DIV, FIX, WB.
- Accept = req_valid & req_ready & ~flush & legal op. Operands and op are latched at the accept edge.
- IDLE transitions on accept:
  - MTHI/MTLO → WB. Result is req_a, targeted at HI only or LO only.
  - MULT/MULTU → MUL.
  - DIV/DIVU with req_b=0 → WB. Result is HI=req_a, LO=0xFFFFFFFF, div_zero=1.
  - DIV/DIVU otherwise → DIV.
- MUL (1 cycle):
  - Registers the 64-bit product.
  - Signed for MULT, with both operands sign-extended to 33 bits; unsigned for MULTU.
  - Next state WB.
- DIV:
  - Signed ops first convert the operands to magnitudes; 0x80000000 → magnitude 2^31, held in 33-bit unsigned.
  - Each cycle performs one restoring step: shift the remainder:quotient pair left one bit, subtract the divisor magnitude, keep the result if non-negative and set the quotient bit.
  - A 5-bit counter runs 0..31; at count 31 the next state is FIX.
- FIX (1 cycle):
  - Signed only: negate the quotient if sign(a)≠sign(b); negate the remainder if a<0.
  - Results are truncated to 32 bits.
  - Unsigned ops pass through unchanged.
  - Next state WB.
- WB (1 cycle):
  - MUL/DIV ops: hi_we=lo_we=1, HI=high word/remainder, LO=low word/quotient.
  - MTHI: only hi_we=1. MTLO: only lo_we=1.
  - Next state IDLE.
- hi_data/lo_data are registered and hold their last value between writes; they are valid only while the matching strobe is high.
- Flush:
  - In MUL/DIV/FIX: next state IDLE, no write, counter cleared.
  - In WB: ignored; the write completes, because the op is already committed.
  - In IDLE: blocks accept that cycle.
- Reset (any state, including mid-divide): state=IDLE, counter=0, hi_we=lo_we=0, hi_data=lo_data=0, div_zero=0, stall=0, req_ready=0 while rst=1.

## Timing
- Accept at edge E0. Strobes are high during the cycle after the stated edge and are sampled by the register file at the following edge:
  - MTHI/MTLO: strobe high after E0, written at E1.
  - MULT/MULTU: MUL after E0, WB after E1, written at E2.
  - DIV/DIVU: DIV for cycles after E0..E31, FIX after E32, WB after E33, written at E34.
  - Divide by zero: WB after E0.
- stall rises the cycle after accept and falls in the cycle after WB. req_ready is therefore low for exactly 1 (MT*/div0), 2 (mult) or 34 (div) cycles.
- Back-to-back: a new request is accepted the first cycle after WB, with no bubble.
- All outputs are registered or decoded from state; there is no combinational path from req_* to any output except req_ready.

## Test plan
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on the next free cycle → exactly one hi_we pulse carrying 0x12345678, then exactly one lo_we pulse carrying 0x9ABCDEF0; the other strobe stays low in each case; each op has stall high for 1 cycle.
- Multiply:
  - MULT a=0xFFFFFFFE (−2), b=3 → WB 2 cycles after accept, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Divide:
  - DIVU 100/7 → WB at accept+34, LO=0x0000000E, HI=0x00000002; stall high for exactly 34 cycles.
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 5/0 → WB at accept+1, HI=5, LO=0xFFFFFFFF, div_zero pulses once.
- Abort and reset:
  - Start DIVU; assert flush at count 10 → IDLE next cycle, no hi_we/lo_we, req_ready=1.
  - Repeat the same sequence with rst instead of flush → same behaviour, and all outputs read 0.
  - Assert flush during WB → the write still occurs.
- Issue MULT immediately after a DIV's WB cycle → accepted with no idle gap; both results are written in order.
- Illegal req_op=6/7 and req_valid during stall → never accepted; HI/LO strobes stay low.
